// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and glyph lookup for the scan controller.
// Patterns are active-low, bit order a,b,c,d,e,f,g,dp with dp left off.
package seg7_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_OFF = 8'hFF;
  localparam seg_t SEG_BAD = 8'hFE;

  localparam seg_t SEG_0 = 8'h03;
  localparam seg_t SEG_1 = 8'h9F;
  localparam seg_t SEG_2 = 8'h25;
  localparam seg_t SEG_3 = 8'h0D;
  localparam seg_t SEG_4 = 8'h99;
  localparam seg_t SEG_5 = 8'h49;
  localparam seg_t SEG_6 = 8'h41;
  localparam seg_t SEG_7 = 8'h1F;
  localparam seg_t SEG_8 = 8'h01;
  localparam seg_t SEG_9 = 8'h09;
  localparam seg_t SEG_A = 8'h11;
  localparam seg_t SEG_B = 8'hC1;
  localparam seg_t SEG_C = 8'h63;
  localparam seg_t SEG_D = 8'h85;
  localparam seg_t SEG_E = 8'h61;
  localparam seg_t SEG_F = 8'h71;

  // Full 0-F glyph table; callers decide whether A-F are allowed.
  function automatic seg_t seg_pattern(input logic [3:0] nib);
    seg_t pat;
    case (nib)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_A;
      4'hB: pat = SEG_B;
      4'hC: pat = SEG_C;
      4'hD: pat = SEG_D;
      4'hE: pat = SEG_E;
      default: pat = SEG_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder; A-F only legal in hex mode,
// otherwise the value is flagged invalid and shown as SEG_BAD.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output seg_t       pattern_c,
  output logic       valid_c
);

  always_comb begin
    valid_c   = hex_mode || (nibble < 4'd10);
    pattern_c = valid_c ? seg_pattern(nibble) : SEG_BAD;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller with double-buffered digit data,
// anti-ghost blanking, blink, decimal points and leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned BLANK_CYC  = 2000,
  parameter int unsigned BLINK_HALF = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  lzb_en,
  output logic [DIGITS-1:0]     ssd_out,
  output logic [7:0]            D,
  output logic                  frame_done
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [PW-1:0]            presc;
  logic [IW-1:0]            idx;
  logic [BW-1:0]            blink_cnt;
  logic                     blink_phase;

  logic [DIGITS-1:0][3:0]   act_digits;
  logic [DIGITS-1:0]        act_dp;
  logic [DIGITS-1:0]        act_blink;
  logic [DIGITS-1:0][3:0]   pend_digits;
  logic [DIGITS-1:0]        pend_dp;
  logic [DIGITS-1:0]        pend_blink;
  logic                     pend_valid;

  logic                     presc_tc_c;
  logic                     frame_end_c;
  logic                     blink_tc_c;
  logic                     lz_run_c;
  logic [DIGITS-1:0]        lz_mask_c;
  logic [3:0]               cur_nibble_c;
  seg_t                     dec_pattern_c;
  logic                     dec_valid_c;
  logic [DIGITS-1:0]        ssd_nxt_c;
  seg_t                     seg_nxt_c;

  assign presc_tc_c   = (presc == PW'(SCAN_DIV - 1));
  assign frame_end_c  = presc_tc_c && (idx == IW'(DIGITS - 1));
  assign blink_tc_c   = (blink_cnt == BW'(BLINK_HALF - 1));
  assign cur_nibble_c = act_digits[idx];

  seg7_decode u_decode (
    .nibble    (cur_nibble_c),
    .hex_mode  (hex_mode),
    .pattern_c (dec_pattern_c),
    .valid_c   (dec_valid_c)
  );

  // Digit i is a leading zero when it and every digit above it are zero.
  always_comb begin
    lz_run_c  = 1'b1;
    lz_mask_c = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run_c     = lz_run_c && (act_digits[i] == 4'd0);
      lz_mask_c[i] = lz_run_c;
    end
  end

  // Next digit-enable and segment values for the current scan position.
  always_comb begin
    ssd_nxt_c = '1;
    seg_nxt_c = SEG_OFF;
    if (presc >= PW'(BLANK_CYC)) begin
      ssd_nxt_c = ~(DIGITS'(1) << idx);
      if (blink_phase && act_blink[idx]) begin
        seg_nxt_c = SEG_OFF;
      end else if (lzb_en && (idx != '0) && lz_mask_c[idx]) begin
        seg_nxt_c = SEG_OFF;
      end else if (!dec_valid_c) begin
        seg_nxt_c = SEG_BAD;
      end else begin
        seg_nxt_c = {dec_pattern_c[7:1], dec_pattern_c[0] & ~act_dp[idx]};
      end
    end
  end

  // Slot prescaler and digit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc_tc_c) begin
      presc <= '0;
      idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Free-running blink half-period timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_tc_c) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  // Double buffer: a load on the boundary bypasses the pending stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_digits  <= '0;
      act_dp      <= '0;
      act_blink   <= '0;
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blink  <= '0;
      pend_valid  <= 1'b0;
    end else if (load && frame_end_c) begin
      act_digits  <= digits_in;
      act_dp      <= dp_in;
      act_blink   <= blink_mask;
      pend_valid  <= 1'b0;
    end else begin
      if (frame_end_c && pend_valid) begin
        act_digits <= pend_digits;
        act_dp     <= pend_dp;
        act_blink  <= pend_blink;
        pend_valid <= 1'b0;
      end
      if (load) begin
        pend_digits <= digits_in;
        pend_dp     <= dp_in;
        pend_blink  <= blink_mask;
        pend_valid  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ssd_out    <= '1;
      D          <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      ssd_out    <= ssd_nxt_c;
      D          <= seg_nxt_c;
      frame_done <= frame_end_c;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a time-indexed reference model queues
// the expected outputs each cycle and a monitor compares them on negedge.
module tb_seg7_scan_ctrl;

  localparam int DIGITS     = 4;
  localparam int SCAN_DIV   = 4;
  localparam int BLANK_CYC  = 1;
  localparam int BLINK_HALF = 64;
  localparam int FRAME      = DIGITS * SCAN_DIV;

  typedef struct packed {
    logic [3:0] ssd;
    logic [7:0] seg;
    logic       fd;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_mask = '0;
  logic        load = 1'b0;
  logic        hex_mode = 1'b0;
  logic        lzb_en = 1'b0;
  logic [3:0]  ssd_out;
  logic [7:0]  D;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  // Reference model state: cycles since reset plus the two data buffers.
  int          t = 0;
  logic [15:0] act_dig = '0, pend_dig = '0;
  logic [3:0]  act_dp = '0, pend_dp = '0, act_bl = '0, pend_bl = '0;
  logic        pend_v = 1'b0;
  obs_t        exp_q [$];
  obs_t        mon_e;

  seg7_scan_ctrl #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .BLINK_HALF(BLINK_HALF)
  ) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
    .blink_mask(blink_mask), .load(load), .hex_mode(hex_mode), .lzb_en(lzb_en),
    .ssd_out(ssd_out), .D(D), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic obs_t model_out(input int tc);
    obs_t       o;
    int         slot;
    logic [3:0] v;
    bit         lead;
    slot  = (tc / SCAN_DIV) % DIGITS;
    o.fd  = (tc % FRAME) == FRAME - 1;
    o.ssd = 4'hF;
    o.seg = 8'hFF;
    if ((tc % SCAN_DIV) >= BLANK_CYC) begin
      o.ssd[slot] = 1'b0;
      v    = act_dig[4*slot +: 4];
      lead = 1'b1;
      for (int j = slot; j < DIGITS; j++) if (act_dig[4*j +: 4] != 4'd0) lead = 1'b0;
      if (((tc / BLINK_HALF) % 2 == 1) && act_bl[slot]) o.seg = 8'hFF;
      else if (lzb_en && slot > 0 && lead) o.seg = 8'hFF;
      else if (v > 4'd9 && !hex_mode) o.seg = 8'hFE;
      else o.seg = seg_tab[v] & ~{7'b0, act_dp[slot]};
    end
    return o;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t        <= 0;
      act_dig  <= '0; act_dp  <= '0; act_bl  <= '0;
      pend_dig <= '0; pend_dp <= '0; pend_bl <= '0;
      pend_v   <= 1'b0;
      exp_q.delete();
    end else begin
      exp_q.push_back(model_out(t));
      if (load && (t % FRAME) == FRAME - 1) begin
        act_dig <= digits_in; act_dp <= dp_in; act_bl <= blink_mask;
        pend_v  <= 1'b0;
      end else begin
        if ((t % FRAME) == FRAME - 1 && pend_v) begin
          act_dig <= pend_dig; act_dp <= pend_dp; act_bl <= pend_bl;
          pend_v  <= 1'b0;
        end
        if (load) begin
          pend_dig <= digits_in; pend_dp <= dp_in; pend_bl <= blink_mask;
          pend_v   <= 1'b1;
        end
      end
      t <= t + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (ssd_out !== 4'hF || D !== 8'hFF || frame_done !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold got ssd=%h D=%h fd=%b exp ssd=f D=ff fd=0", ssd_out, D, frame_done);
      end
    end else if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({ssd_out, D, frame_done} !== mon_e) begin
        failures++;
        $display("FAIL sb time=%0t got ssd=%h D=%h fd=%b exp ssd=%h D=%h fd=%b",
                 $time, ssd_out, D, frame_done, mon_e.ssd, mon_e.seg, mon_e.fd);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wait_fd(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < 64);
    check({name, "_fd"}, 32'(frame_done), 32'd1);
  endtask

  task automatic find_slot(input string name, input int digit, output logic [7:0] seg);
    logic [3:0] want;
    int n = 0;
    want = ~(4'b0001 << digit);
    do begin @(negedge clk); n++; end while (ssd_out !== want && n < 64);
    check({name, "_sel"}, 32'(ssd_out), 32'(want));
    seg = D;
  endtask

  task automatic expect_slot(input string name, input int digit, input logic [7:0] exp);
    logic [7:0] seg;
    find_slot(name, digit, seg);
    check(name, 32'(seg), 32'(exp));
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    digits_in = d; dp_in = dp; blink_mask = bl; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] r;
    for (int j = 0; j < DIGITS; j++)
      r[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return r;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b1;
    int n;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ssd", 32'(ssd_out), 32'hF);
    check("reset_D", 32'(D), 32'hFF);
    rst = 1'b1;

    // Scan and basic load.
    do_load(16'h1234, 4'b0000, 4'b0000);
    wait_fd("scan");
    expect_slot("scan_d0", 0, 8'h99);
    expect_slot("scan_d1", 1, 8'h0D);
    expect_slot("scan_d2", 2, 8'h25);
    expect_slot("scan_d3", 3, 8'h9F);
    wait_fd("period_a");
    n = 0;
    do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < 64);
    check("frame_period", 32'(n), 32'(FRAME));

    // Double buffering: last load wins, boundary load applies immediately.
    do_load(16'h1111, 4'b0000, 4'b0000);
    repeat (2) @(negedge clk);
    do_load(16'h2222, 4'b0000, 4'b0000);
    wait_fd("dbuf");
    for (int i = 0; i < DIGITS; i++) expect_slot("dbuf_slot", i, 8'h25);
    wait_fd("bnd");
    repeat (FRAME - 1) @(negedge clk);
    do_load(16'h3333, 4'b0000, 4'b0000);
    expect_slot("bnd_d0", 0, 8'h0D);

    // Hex mode and leading-zero blanking.
    do_load(16'h00AB, 4'b0000, 4'b0000);
    wait_fd("modes");
    expect_slot("dec_d0", 0, 8'hFE);
    expect_slot("dec_d1", 1, 8'hFE);
    hex_mode = 1'b1;
    expect_slot("hex_d0", 0, 8'hC1);
    expect_slot("hex_d1", 1, 8'h11);
    lzb_en = 1'b1;
    expect_slot("lzb_d2", 2, 8'hFF);
    expect_slot("lzb_d3", 3, 8'hFF);
    expect_slot("lzb_d0", 0, 8'hC1);
    hex_mode = 1'b0;
    lzb_en   = 1'b0;

    // Blink and decimal point.
    do_load(16'h0005, 4'b0010, 4'b0001);
    wait_fd("blink");
    expect_slot("dp_d1", 1, 8'h02);
    find_slot("blink_a", 0, b1);
    check("blink_a_val", 32'(b1 == 8'h49 || b1 == 8'hFF), 32'd1);
    repeat (BLINK_HALF) @(negedge clk);
    check("blink_b_sel", 32'(ssd_out), 32'hE);
    check("blink_b", 32'(D), (b1 == 8'h49) ? 32'hFF : 32'h49);

    // Mid-scan reset discards a pending load.
    do_load(16'h9876, 4'b1111, 4'b0000);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_async_ssd", 32'(ssd_out), 32'hF);
    check("rst_async_D", 32'(D), 32'hFF);
    check("rst_async_fd", 32'(frame_done), 32'd0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (ssd_out === 4'hF && n < 16);
    check("rst_first_dig", 32'(ssd_out), 32'hE);
    check("rst_first_lat", 32'(n), 32'd2);
    wait_fd("rst_pend");
    expect_slot("rst_pend_d0", 0, 8'h03);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        digits_in  = rand_digits();
        dp_in      = 4'($urandom);
        blink_mask = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
        load       = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 63) == 0) hex_mode = ~hex_mode;
      if ($urandom_range(0, 63) == 0) lzb_en = ~lzb_en;
    end
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
